score_display_ctrl: RTL and testbench
=====================================

Name: score_display_ctrl

Overview:
Game-level controller for the score HUD. It owns the run/over state machine, a 4-digit BCD score and a 4-digit BCD high score. Per pixel, it selects which single digit the shared 7-segment pixel renderer draws, and supplies that digit's value and on-screen origin. It sits between the game logic (start, collision, bonus, frame tick), the VGA timing block (x, y, video_on) and one shared segment renderer instance.

Parameters:
NUM_DIGITS, 4, digits per number; the fixed BCD width is 4*NUM_DIGITS.
SCORE_X, 560, x origin of the score's most significant digit.
SCORE_Y, 10, y origin of the score row.
HI_X, 440, x origin of the high score's most significant digit.
HI_Y, 10, y origin of the high score row.
DIGIT_PITCH, 12, x step between digit origins; must be at least 10 (cell width).
AUTO_DIV, 6, frame ticks per automatic +1 while running; range 1..255.
BLANK_LZ, 1, 1 blanks leading zeros except the least significant digit.

Ports:
clk  in  1  system clock.
rst_n  in  1  synchronous active-low reset.
start  in  1  one-cycle pulse; begins a new run.
collide  in  1  one-cycle pulse; ends the current run.
bonus  in  1  one-cycle pulse; adds +1 to the score.
frame_tick  in  1  one-cycle pulse per video frame.
video_on  in  1  visible-area flag from VGA timing.
x  in  10  current pixel column.
y  in  10  current pixel row.
running  out  1  high while in RUN.
score_bcd  out  16  current score, 4 BCD digits, MSD in [15:12].
hiscore_bcd  out  16  high score, same layout.
digit_num  out  4  BCD value for the segment renderer.
seg_x  out  10  origin x of the selected digit cell.
seg_y  out  10  origin y of the selected digit cell.
digit_en  out  1  renderer output is valid for this pixel.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State goes to IDLE.
  - score, hiscore, div_cnt, running, digit_num, seg_x, seg_y and digit_en all go to 0.
- States: IDLE=0, RUN=1, OVER=2; 3 is illegal and recovers to IDLE on the next edge.
- IDLE or OVER with start=1:
  - Next state is RUN.
  - score and div_cnt are cleared to 0.
  - hiscore is unchanged.
- RUN:
  - start is ignored.
  - collide=1 moves to OVER, freezes the score and sets hiscore to max(hiscore, score). The compare is a lexicographic BCD compare, MSD first.
  - collide has priority: bonus and auto increments in that same cycle are dropped.
- Auto increment (RUN, no collide):
  - On frame_tick, div_cnt advances.
  - When div_cnt reaches AUTO_DIV-1, div_cnt returns to 0 and an auto +1 is issued.
- Increment amount:
  - bonus alone or auto alone adds +1.
  - bonus and auto in the same cycle adds +2.
  - The result saturates at 9999 and never wraps.
  - Each digit stays in 0..9; carry ripples from LSD to MSD.
- Timing: score and hiscore update on the clock edge after the triggering pulse (1-cycle latency). running is registered.
- Display select is registered, with 1-cycle latency from x/y to the outputs:
  - Score window i (i=0 is MSD) covers x in [SCORE_X+i*DIGIT_PITCH, +9] and y in [SCORE_Y, SCORE_Y+19].
  - The high score window is the same shape, using HI_X and HI_Y.
  - Inside a window: digit_num is the corresponding BCD digit, seg_x/seg_y is the window origin, and digit_en=1.
  - If score and hiscore windows overlap, the score wins.
  - digit_en is forced to 0 when video_on=0.
  - With BLANK_LZ=1, digit_en is forced to 0 for a zero digit when all more-significant digits are also zero; the LSD is never blanked.
  - Outside every window: digit_en=0, digit_num=0, seg_x=0, seg_y=0.
- The displayed value reflects the register contents at the cycle the pixel is sampled.
- Reset asserted mid-run clears everything, hiscore included.

Decomposition:
- Shared include score_defs.vh holds:
  - state encodings (IDLE/RUN/OVER);
  - SEG_W=10, SEG_H=20;
  - BCD_MAX=16'h9999.
- Sub-module bcd_sat_inc: combinational 4-digit BCD +1 with saturation, used twice in series to realise +2.
- The BCD max/compare is a function in the include file.

Test Plan:
- Reset, then start, then 12 frame_ticks with AUTO_DIV=6 -> score_bcd=16'h0002 and running=1.
- Preload the score to 0999 via bonus pulses, then one more bonus -> 16'h1000. Continue to 9999, then one more bonus -> stays 16'h9999.
- In RUN, assert collide together with bonus and an auto increment in the same cycle -> state OVER, score unchanged, hiscore=score. A second run ending at 0005 after a 0042 high score -> hiscore stays 16'h0042.
- bonus coincident with the 6th frame_tick at score 0007 -> 16'h0009. start pulse while in RUN -> no effect.
- Score 0042, x=SCORE_X+2*DIGIT_PITCH+3, y=SCORE_Y+5 -> next cycle digit_num=4, seg_x=584, seg_y=10, digit_en=1. The same pixel on MSD (x=SCORE_X) -> digit_en=0 due to blanking. video_on=0 -> digit_en=0.
- rst_n low for one cycle during RUN with hiscore 0042 -> state IDLE; score, hiscore and all display outputs return to 0.

Source files
------------

// File: rtl/score_display_ctrl_pkg.sv
// Shared definitions for the score HUD controller: game states, digit cell
// geometry, BCD limits and small helpers used by the controller datapath.
package score_display_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2,
    ST_BAD  = 2'd3
  } state_t;

  localparam int SEG_W = 10;
  localparam int SEG_H = 20;
  localparam logic [15:0] BCD_MAX = 16'h9999;

  // Larger of two 4-digit BCD values, compared digit by digit from the MSD.
  function automatic logic [15:0] bcd_max(input logic [15:0] a, input logic [15:0] b);
    logic a_gt;
    logic decided;
    a_gt    = 1'b0;
    decided = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
        decided = 1'b1;
        a_gt    = (a[4*i +: 4] > b[4*i +: 4]);
      end
    end
    return a_gt ? a : b;
  endfunction

  // True when pixel (px, py) lies inside the digit cell whose origin is (ox, oy).
  function automatic logic in_cell(input logic [9:0] px, input logic [9:0] py,
                                   input int ox, input int oy);
    int xi;
    int yi;
    xi = int'(px);
    yi = int'(py);
    return (xi >= ox) && (xi < ox + SEG_W) && (yi >= oy) && (yi < oy + SEG_H);
  endfunction

endpackage

// File: rtl/score_display_ctrl_bcd_sat_inc.sv
// Combinational BCD +1 with saturation: an all-nines input is passed through
// unchanged, otherwise the carry ripples from the least significant digit up.
module bcd_sat_inc #(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic [4*NUM_DIGITS-1:0] bcd_out
);

  // Ripple increment, then override with the input when already at the maximum.
  always_comb begin
    logic all_nine;
    logic carry;
    bcd_out  = bcd_in;
    all_nine = 1'b1;
    carry    = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_in[4*i +: 4] != 4'd9) all_nine = 1'b0;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (bcd_in[4*i +: 4] == 4'd9) begin
          bcd_out[4*i +: 4] = 4'd0;
        end else begin
          bcd_out[4*i +: 4] = bcd_in[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (all_nine) bcd_out = bcd_in;
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Score HUD controller: run/over state machine, BCD score and high score,
// and per-pixel selection of the digit drawn by the shared segment renderer.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | after reset, waiting for start
//   RUN     | game running, score counts up on bonus and frame ticks
//   OVER    | run ended by collision, score frozen, waiting for start
//   (3)     | unreachable encoding, returns to IDLE on the next edge
module score_display_ctrl
  import score_display_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCORE_X     = 560,
  parameter int SCORE_Y     = 10,
  parameter int HI_X        = 440,
  parameter int HI_Y        = 10,
  parameter int DIGIT_PITCH = 12,
  parameter int AUTO_DIV    = 6,
  parameter int BLANK_LZ    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    collide,
  input  logic                    bonus,
  input  logic                    frame_tick,
  input  logic                    video_on,
  input  logic [9:0]              x,
  input  logic [9:0]              y,
  output logic                    running,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [4*NUM_DIGITS-1:0] hiscore_bcd,
  output logic [3:0]              digit_num,
  output logic [9:0]              seg_x,
  output logic [9:0]              seg_y,
  output logic                    digit_en
);

  localparam int W = 4 * NUM_DIGITS;

  state_t       state;
  state_t       state_next;
  logic [W-1:0] score;
  logic [W-1:0] hiscore;
  logic [W-1:0] score_next;
  logic [W-1:0] hiscore_next;
  logic [W-1:0] inc1;
  logic [W-1:0] inc2;
  logic [7:0]   div_cnt;
  logic [7:0]   div_next;
  logic         auto_inc;
  logic         running_next;

  logic [3:0]   disp_num;
  logic [9:0]   disp_x;
  logic [9:0]   disp_y;
  logic         disp_en;
  logic [3:0]   hi_d;
  logic [3:0]   sc_d;
  logic         lz_hi;
  logic         lz_sc;

  assign score_bcd   = score;
  assign hiscore_bcd = hiscore;

  // +2 is two saturating +1 stages in series, so 9998 + 2 lands on 9999.
  bcd_sat_inc #(.NUM_DIGITS(NUM_DIGITS)) u_inc1 (.bcd_in(score), .bcd_out(inc1));
  bcd_sat_inc #(.NUM_DIGITS(NUM_DIGITS)) u_inc2 (.bcd_in(inc1),  .bcd_out(inc2));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; collide ends a run, start begins one from IDLE or OVER.
  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE, ST_OVER: state_next = start ? ST_RUN : state;
      ST_RUN:           state_next = collide ? ST_OVER : ST_RUN;
      default:          state_next = ST_IDLE;
    endcase
  end

  // Datapath next values: score clear on start, auto divider, increments, high score latch.
  always_comb begin
    score_next   = score;
    hiscore_next = hiscore;
    div_next     = div_cnt;
    auto_inc     = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          score_next = '0;
          div_next   = '0;
        end
      end
      ST_RUN: begin
        if (collide) begin
          // Bonus and auto increments in the collision cycle are dropped.
          hiscore_next = bcd_max(hiscore, score);
        end else begin
          if (frame_tick) begin
            if (div_cnt == 8'(AUTO_DIV - 1)) begin
              div_next = '0;
              auto_inc = 1'b1;
            end else begin
              div_next = div_cnt + 8'd1;
            end
          end
          case ({bonus, auto_inc})
            2'b11:        score_next = inc2;
            2'b10, 2'b01: score_next = inc1;
            default:      score_next = score;
          endcase
        end
      end
      default: ;
    endcase
    running_next = (state_next == ST_RUN);
  end

  // Game registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      score   <= '0;
      hiscore <= '0;
      div_cnt <= '0;
      running <= 1'b0;
    end else begin
      score   <= score_next;
      hiscore <= hiscore_next;
      div_cnt <= div_next;
      running <= running_next;
    end
  end

  // Pixel-to-digit select; score windows are evaluated last so they win any overlap.
  always_comb begin
    disp_num = '0;
    disp_x   = '0;
    disp_y   = '0;
    disp_en  = 1'b0;
    hi_d     = '0;
    sc_d     = '0;
    lz_hi    = 1'b1;
    lz_sc    = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hi_d  = hiscore[W-4-4*i +: 4];
      lz_hi = lz_hi && (hi_d == 4'd0);
      if (in_cell(x, y, HI_X + i*DIGIT_PITCH, HI_Y)) begin
        disp_num = hi_d;
        disp_x   = 10'(HI_X + i*DIGIT_PITCH);
        disp_y   = 10'(HI_Y);
        disp_en  = !((BLANK_LZ != 0) && lz_hi && (i != NUM_DIGITS-1));
      end
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sc_d  = score[W-4-4*i +: 4];
      lz_sc = lz_sc && (sc_d == 4'd0);
      if (in_cell(x, y, SCORE_X + i*DIGIT_PITCH, SCORE_Y)) begin
        disp_num = sc_d;
        disp_x   = 10'(SCORE_X + i*DIGIT_PITCH);
        disp_y   = 10'(SCORE_Y);
        disp_en  = !((BLANK_LZ != 0) && lz_sc && (i != NUM_DIGITS-1));
      end
    end
    if (!video_on) disp_en = 1'b0;
  end

  // Display output registers, one cycle behind x/y.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_num <= '0;
      seg_x     <= '0;
      seg_y     <= '0;
      digit_en  <= 1'b0;
    end else begin
      digit_num <= disp_num;
      seg_x     <= disp_x;
      seg_y     <= disp_y;
      digit_en  <= disp_en;
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench for score_display_ctrl: stimulus pushes the expected
// post-edge outputs from an integer reference model, a monitor pops them.
module tb_score_display_ctrl;

  localparam int SCORE_X = 560;
  localparam int SCORE_Y = 10;
  localparam int HI_X    = 440;
  localparam int HI_Y    = 10;
  localparam int PITCH   = 12;
  localparam int AUTO_DIV = 6;

  logic       clk = 1'b0;
  logic       rst_n, start, collide, bonus, frame_tick, video_on;
  logic [9:0] x, y;
  logic       running;
  logic [15:0] score_bcd, hiscore_bcd;
  logic [3:0] digit_num;
  logic [9:0] seg_x, seg_y;
  logic       digit_en;

  score_display_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .collide(collide), .bonus(bonus),
    .frame_tick(frame_tick), .video_on(video_on), .x(x), .y(y),
    .running(running), .score_bcd(score_bcd), .hiscore_bcd(hiscore_bcd),
    .digit_num(digit_num), .seg_x(seg_x), .seg_y(seg_y), .digit_en(digit_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sc;
    logic [15:0] hi;
    logic        run;
    logic [3:0]  dn;
    logic [9:0]  sx;
    logic [9:0]  sy;
    logic        en;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain integers, 0 idle / 1 run / 2 over.
  int m_st = 0;
  int m_score = 0;
  int m_hi = 0;
  int m_div = 0;

  function automatic int pow10(input int n);
    int p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected display contribution of one number's four windows.
  task automatic disp_model(input int val, input int ox0, input int oy, input int px, input int py,
                            inout exp_t e);
    for (int i = 0; i < 4; i++) begin
      int ox = ox0 + i * PITCH;
      if (px >= ox && px <= ox + 9 && py >= oy && py <= oy + 19) begin
        e.dn = 4'((val / pow10(3 - i)) % 10);
        e.sx = 10'(ox);
        e.sy = 10'(oy);
        e.en = !(i < 3 && val < pow10(3 - i));
      end
    end
  endtask

  // Drive one cycle of inputs, push the expected result, advance to the next negedge.
  task automatic step(input logic r, input logic s, input logic c, input logic b,
                      input logic t, input logic v, input int px, input int py);
    exp_t e;
    int auto_i;
    rst_n = r; start = s; collide = c; bonus = b; frame_tick = t; video_on = v;
    x = 10'(px); y = 10'(py);
    e.dn = '0; e.sx = '0; e.sy = '0; e.en = 1'b0;
    if (r) begin
      disp_model(m_hi, HI_X, HI_Y, px, py, e);
      disp_model(m_score, SCORE_X, SCORE_Y, px, py, e);
      if (!v) e.en = 1'b0;
    end
    if (!r) begin
      m_st = 0; m_score = 0; m_hi = 0; m_div = 0;
    end else if (m_st != 1) begin
      if (s) begin m_st = 1; m_score = 0; m_div = 0; end
    end else if (c) begin
      m_st = 2;
      if (m_score > m_hi) m_hi = m_score;
    end else begin
      auto_i = 0;
      if (t) begin
        if (m_div == AUTO_DIV - 1) begin m_div = 0; auto_i = 1; end
        else m_div++;
      end
      m_score = m_score + int'(b) + auto_i;
      if (m_score > 9999) m_score = 9999;
    end
    e.sc = to_bcd(m_score);
    e.hi = to_bcd(m_hi);
    e.run = (m_st == 1);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic pick_pixel(output int px, output int py);
    if ($urandom_range(0, 1) == 0) begin
      px = ($urandom_range(0, 1) == 0 ? SCORE_X : HI_X) + int'($urandom_range(0, 3)) * PITCH
           + int'($urandom_range(0, 11));
      py = 8 + int'($urandom_range(0, 23));
    end else begin
      px = int'($urandom_range(0, 639));
      py = int'($urandom_range(0, 479));
    end
  endtask

  task automatic idle_step(input logic s, input logic c, input logic b, input logic t);
    int px, py;
    pick_pixel(px, py);
    step(1'b1, s, c, b, t, 1'b1, px, py);
  endtask

  // Monitor: compares every registered output against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("score_bcd",   score_bcd,          e.sc);
        chk("hiscore_bcd", hiscore_bcd,        e.hi);
        chk("running",     16'(running),       16'(e.run));
        chk("digit_num",   16'(digit_num),     16'(e.dn));
        chk("seg_x",       16'(seg_x),         16'(e.sx));
        chk("seg_y",       16'(seg_y),         16'(e.sy));
        chk("digit_en",    16'(digit_en),      16'(e.en));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 0; collide = 0; bonus = 0; frame_tick = 0; video_on = 0; x = '0; y = '0;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, SCORE_X, SCORE_Y);

    // Auto increment: 12 ticks at divide-by-6 gives 2.
    idle_step(1, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      idle_step(0, 0, 0, 1);
      idle_step(0, 0, 0, 0);
    end
    chk("auto12_score", score_bcd, 16'h0002);
    chk("auto12_running", 16'(running), 16'h0001);

    // Collide together with bonus and a due auto increment.
    for (int k = 0; k < 5; k++) idle_step(0, 0, 0, 1);
    idle_step(0, 1, 1, 1);
    chk("collide_score", score_bcd, 16'h0002);
    chk("collide_hi", hiscore_bcd, 16'h0002);

    // High score 42, then a shorter run keeps it.
    idle_step(1, 0, 0, 0);
    for (int k = 0; k < 42; k++) idle_step(0, 0, 1, 0);
    idle_step(0, 1, 0, 0);
    idle_step(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) idle_step(0, 0, 1, 0);
    idle_step(0, 1, 0, 0);
    chk("hi_kept", hiscore_bcd, 16'h0042);

    // Display of score 0042.
    idle_step(1, 0, 0, 0);
    for (int k = 0; k < 42; k++) idle_step(0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, SCORE_X + 2*PITCH + 3, SCORE_Y + 5);
    chk("disp_num", 16'(digit_num), 16'h0004);
    chk("disp_segx", 16'(seg_x), 16'd584);
    chk("disp_en", 16'(digit_en), 16'h0001);
    step(1, 0, 0, 0, 0, 1, SCORE_X, SCORE_Y + 5);
    chk("blank_msd", 16'(digit_en), 16'h0000);
    step(1, 0, 0, 0, 0, 0, SCORE_X + 2*PITCH + 3, SCORE_Y + 5);
    idle_step(1, 0, 0, 0);
    chk("start_in_run", score_bcd, 16'h0042);

    // Bonus coincident with the 6th tick at score 7.
    idle_step(0, 1, 0, 0);
    idle_step(1, 0, 0, 0);
    for (int k = 0; k < 7; k++) idle_step(0, 0, 1, 0);
    for (int k = 0; k < 5; k++) idle_step(0, 0, 0, 1);
    idle_step(0, 0, 1, 1);
    chk("bonus_plus_auto", score_bcd, 16'h0009);

    // Bonus run to saturation (0999 -> 1000 on the way).
    for (int k = 0; k < 10000; k++) idle_step(0, 0, 1, 0);
    chk("saturate", score_bcd, 16'h9999);

    // Reset mid-run clears everything.
    step(0, 0, 0, 1, 1, 1, SCORE_X + 40, SCORE_Y + 2);
    chk("rst_hi", hiscore_bcd, 16'h0000);
    chk("rst_en", 16'(digit_en), 16'h0000);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      int px, py;
      pick_pixel(px, py);
      step($urandom_range(0, 999) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) != 0, px, py);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
